// File: rtl/pipe_hazard_ctrl.sv
// RV32I issue controller: register scoreboard, RAW stall, redirect flush and debug halt sequencing.
// Issue decisions are combinational from the decode inputs and the registered scoreboard/FSM state.
module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        id_rs1_re,
  input  logic [4:0]  id_rs1_addr,
  input  logic        id_rs2_re,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rd_we,
  input  logic [4:0]  id_rd_addr,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic        ex_redirect,
  input  logic        halt_req,
  input  logic        resume_req,
  output logic        id_issue,
  output logic        stall_if,
  output logic        stall_id,
  output logic        flush_id,
  output logic [31:0] busy_vec,
  output logic        halted,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StFlush  = 2'd1,
    StDrain  = 2'd2,
    StHalted = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] busy_q, busy_d;
  logic        halted_q, halted_d;
  logic        rs1_haz, rs2_haz;

  // Same-cycle writeback counts as ready because the regfile writes through.
  assign rs1_haz = id_rs1_re && busy_q[id_rs1_addr] && !(wb_we && (wb_addr == id_rs1_addr));
  assign rs2_haz = id_rs2_re && busy_q[id_rs2_addr] && !(wb_we && (wb_addr == id_rs2_addr));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      cnt_q    <= 3'd0;
      busy_q   <= 32'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (ex_redirect) begin
          state_d = StFlush;
          cnt_d   = 3'(FLUSH_CYCLES);
        end else if (halt_req) begin
          state_d = StDrain;
        end
      end
      StFlush: begin
        if (ex_redirect) begin
          cnt_d = 3'(FLUSH_CYCLES);
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = halt_req ? StDrain : StRun;
          end
        end
      end
      StDrain: begin
        if ((busy_q == 32'd0) && !wb_we) begin
          state_d = StHalted;
        end
      end
      StHalted: begin
        if (resume_req && !halt_req) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
    halted_d = (state_d == StHalted);
  end

  always_comb begin
    id_issue = id_valid && (state_q == StRun) && !rs1_haz && !rs2_haz && !ex_redirect;
    flush_id = ex_redirect || (state_q == StFlush);
    stall_id = id_valid && !id_issue && !flush_id;
    stall_if = stall_id || (state_q == StDrain) || (state_q == StHalted);
  end

  // Set after clear so a newer writer to the same index stays pending.
  always_comb begin
    busy_d = busy_q;
    if (wb_we && (wb_addr != 5'd0)) begin
      busy_d[wb_addr] = 1'b0;
    end
    if (id_issue && id_rd_we && (id_rd_addr != 5'd0)) begin
      busy_d[id_rd_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  assign busy_vec = busy_q;
  assign halted   = halted_q;
  assign state    = state_q;

endmodule
